fetch_steer_queue: RTL and testbench
====================================

# fetch_steer_queue

Front-end instruction queue between the fetch stage and the decoder. Each fetched (pc, inst) beat is pre-decoded by `pre_decoder` as it is pushed; static predictions steer fetch with a one-cycle redirect pulse. An epoch tag discards in-flight wrong-path beats. Backend flushes override everything.

## Interface
- `DEPTH`, 8, queue entries; power of two, at least 2
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `if_valid`  in  1  fetch beat valid
- `if_ready`  out  1  queue can accept a beat
- `if_pc`  in  32  beat PC
- `if_inst`  in  32  beat instruction
- `if_epoch`  in  2  epoch the beat was fetched under (echo of `cur_epoch` at request time)
- `cur_epoch`  out  2  current fetch epoch
- `redir_valid`  out  1  one-cycle redirect pulse to fetch
- `redir_pc`  out  32  redirect target
- `id_valid`  out  1  head entry valid
- `id_ready`  in  1  decoder consumes head
- `id_pc`, `id_inst`  out  32 each  head entry
- `id_pred_taken`  out  1  head entry predicted taken
- `id_pred_pc`  out  32  predicted next PC of head entry
- `be_flush`  in  1  backend flush (mispredict, jirl resolution, exception)
- `be_flush_pc`  in  32  flush target
- `occupancy`  out  log2(DEPTH)+1  entries held

## Operation
- Pre-decode categories: 00 plain, 01 conditional branch, 10 b/bl, 11 jirl.
- Accept condition: `if_valid && if_ready && if_epoch==cur_epoch && state==RUN && !be_flush`. Beats with a mismatched epoch, or beats that arrive in BLOCK, handshake normally and are dropped.
- Prediction per accepted beat:
  - category 10: taken.
  - category 01 with `inst[25]==1` (backward): taken.
  - category 01 forward: not taken.
  - category 00: not taken.
  - category 11: not taken; enters BLOCK.
- Taken target `pc + pc_offset`, mod 2^32. Not-taken target `pc + 4`. The target is stored with the entry as `id_pred_pc`.
- Taken accept: register `redir_valid=1`, `redir_pc=target`, `cur_epoch += 1` (2-bit wrap).
- States:
  - RUN -> BLOCK on an accepted category-11 beat. The jirl beat itself is enqueued.
  - BLOCK -> RUN only on `be_flush`.
  - `be_flush` in any state -> RUN.
- `be_flush` has top priority:
  - empties the queue and drops any same-cycle accept and pop;
  - sets `redir_valid=1`, `redir_pc=be_flush_pc`, `cur_epoch += 1`;
  - wins over a same-cycle predecode redirect.
- FIFO:
  - `if_ready = (occupancy != DEPTH)`, also valid in BLOCK.
  - Push and pop in the same cycle are allowed whenever not full. The count is then unchanged.
  - No bypass when full: pop frees the slot for the next cycle.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
- Reset values:
  - `occupancy=0`, `id_valid=0`, `if_ready=1`;
  - `redir_valid=0`, `redir_pc=0`, `cur_epoch=0`;
  - state RUN, pointers 0;
  - id data outputs 0.

## Timing
- A beat accepted at cycle N appears at the head at N+1 at the earliest (`id_valid` follows registered occupancy).
- Redirect is registered: accept at N gives `redir_valid` high exactly during N+1, and `cur_epoch` new from N+1.
- Beats presented at N+1 carrying the old epoch are dropped.
- `be_flush` at N gives, at N+1: `occupancy=0`, `id_valid=0`, the redirect pulse, and the new epoch.
- `id_*` and `if_ready` are combinational from registers only. There is no input-to-output combinational path except `pre_decoder` feeding the storage write.
- An asynchronous `rstn` mid-operation clears everything immediately. The first redirect after reset comes only from `be_flush`.

## Structure
- Shared package holds:
  - category encoding constants (`CAT_PLAIN`, `CAT_BCOND`, `CAT_B`, `CAT_JIRL`);
  - state encoding (RUN, BLOCK);
  - epoch width (2).
- One sub-module instance: the existing `pre_decoder` on the `if_inst` path.
- FIFO storage is inline. Per-entry fields: pc, inst, pred_taken, pred_pc.

## Test plan
- Reset, push plain beats pc=0x1c000000..0x1c00000c with `id_ready=0` -> `occupancy=4`, `if_ready=1`. Fill to 8 -> `if_ready=0`. One pop -> next cycle `if_ready=1`.
- Accept b with offset +0x40 at pc 0x1c000100 -> next cycle `redir_valid=1`, `redir_pc=0x1c000140`, `cur_epoch=1`. A beat at pc 0x1c000104 with epoch 0 is dropped.
- Backward bne (`inst[25]=1`, offset -8) at 0x1c000200 -> redirect to 0x1c0001f8, `id_pred_taken=1`. Forward beq -> no redirect, `id_pred_pc=pc+4`.
- jirl accepted -> BLOCK. Next 3 beats are handshaken and dropped, occupancy unchanged. `be_flush` with pc 0x1c008000 -> RUN, queue empty, redirect 0x1c008000.
- Same cycle: taken b accepted and `be_flush` pc 0x1c000800 -> single redirect to 0x1c000800, queue empty, epoch +1 only.
- Queue full with simultaneous pop, then `rstn` low mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_steer_queue_pkg.sv
// Shared definitions for the fetch steering queue: pre-decode categories,
// control state encoding, epoch width, opcode constants and the entry layout.
package fetch_steer_queue_pkg;

   // Width of the fetch epoch tag carried with every beat.
   localparam int EPOCH_W = 2;

   // Pre-decode categories.
   typedef enum logic [1:0] {
      CAT_PLAIN = 2'b00,
      CAT_BCOND = 2'b01,
      CAT_B     = 2'b10,
      CAT_JIRL  = 2'b11
   } cat_e;

   // Control state: RUN accepts beats, BLOCK waits for the backend to
   // resolve an indirect jump.
   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_BLOCK = 1'b1
   } fsq_state_e;

   // Major opcodes (inst[31:26]) recognised by the pre-decoder.
   localparam logic [5:0] OP_JIRL = 6'h13;
   localparam logic [5:0] OP_B    = 6'h14;
   localparam logic [5:0] OP_BL   = 6'h15;
   localparam logic [5:0] OP_BEQ  = 6'h16;
   localparam logic [5:0] OP_BGEU = 6'h1b;

   // One queue entry as presented to the decoder.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred_taken;
      logic [31:0] pred_pc;
   } fsq_entry_t;

   // Static prediction: unconditional direct branches are taken, conditional
   // branches are taken only when their offset is negative (backward loop).
   function automatic logic predict_taken(input cat_e cat, input logic offset_sign);
      return (cat == CAT_B) || ((cat == CAT_BCOND) && offset_sign);
   endfunction

endpackage

// File: rtl/fetch_steer_queue_pre_decoder.sv
// Purely combinational pre-decoder: classifies a fetched instruction and
// extracts its sign-extended, byte-scaled PC-relative offset.
module pre_decoder
   import fetch_steer_queue_pkg::*;
(
   input  logic [31:0] inst_i,
   output cat_e        cat_o,
   output logic [31:0] offset_o
);

   logic [5:0] opcode;

   assign opcode = inst_i[31:26];

   // Category and offset decode. beqz/bnez carry a split 21-bit offset whose
   // sign is not inst[25]; they are treated as plain and left to the backend.
   always_comb begin
      cat_o    = CAT_PLAIN;
      offset_o = '0;
      if (opcode == OP_JIRL) begin
         cat_o    = CAT_JIRL;
         offset_o = {{14{inst_i[25]}}, inst_i[25:10], 2'b00};
      end else if ((opcode == OP_B) || (opcode == OP_BL)) begin
         cat_o    = CAT_B;
         offset_o = {{4{inst_i[9]}}, inst_i[9:0], inst_i[25:10], 2'b00};
      end else if ((opcode >= OP_BEQ) && (opcode <= OP_BGEU)) begin
         cat_o    = CAT_BCOND;
         offset_o = {{14{inst_i[25]}}, inst_i[25:10], 2'b00};
      end
   end

endmodule

// File: rtl/fetch_steer_queue.sv
// Front-end instruction queue between fetch and decode. Beats are pre-decoded
// on push, statically predicted, and stored with their predicted next PC.
// Taken predictions and backend flushes steer fetch through a registered
// one-cycle redirect and bump the fetch epoch so stale beats are discarded.
module fetch_steer_queue
   import fetch_steer_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     if_valid,
   output logic                     if_ready,
   input  logic [31:0]              if_pc,
   input  logic [31:0]              if_inst,
   input  logic [EPOCH_W-1:0]       if_epoch,
   output logic [EPOCH_W-1:0]       cur_epoch,
   output logic                     redir_valid,
   output logic [31:0]              redir_pc,
   output logic                     id_valid,
   input  logic                     id_ready,
   output logic [31:0]              id_pc,
   output logic [31:0]              id_inst,
   output logic                     id_pred_taken,
   output logic [31:0]              id_pred_pc,
   input  logic                     be_flush,
   input  logic [31:0]              be_flush_pc,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Control registers and their next-state values.
   fsq_state_e          state_q, state_d;
   logic [EPOCH_W-1:0]  epoch_q, epoch_d;
   logic                redir_valid_q, redir_valid_d;
   logic [31:0]         redir_pc_q, redir_pc_d;
   logic [PTR_W-1:0]    wptr_q, wptr_d;
   logic [PTR_W-1:0]    rptr_q, rptr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   // Storage and write-side signals.
   fsq_entry_t          mem_q [DEPTH];
   fsq_entry_t          wr_entry;
   fsq_entry_t          head_entry;

   cat_e                dec_cat;
   logic [31:0]         dec_offset;
   logic                wr_taken;
   logic [31:0]         wr_target;

   logic                full;
   logic                empty;
   logic                accept;
   logic                pop;

   pre_decoder u_pre_decoder (
      .inst_i   (if_inst),
      .cat_o    (dec_cat),
      .offset_o (dec_offset)
   );

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // A beat is stored only when it belongs to the current epoch, the queue is
   // running and no flush is discarding this cycle's work. Everything else
   // that sees if_ready still completes its handshake and is dropped.
   assign accept = if_valid && !full && (if_epoch == epoch_q) &&
                   (state_q == ST_RUN) && !be_flush;
   assign pop    = id_ready && !empty && !be_flush;

   // Static prediction and predicted next PC for the incoming beat.
   always_comb begin
      wr_taken  = predict_taken(dec_cat, if_inst[25]);
      wr_target = wr_taken ? (if_pc + dec_offset) : (if_pc + 32'd4);
      wr_entry  = '{pc: if_pc, inst: if_inst, pred_taken: wr_taken, pred_pc: wr_target};
   end

   // Entry storage; contents are qualified by occupancy so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wptr_q] <= wr_entry;
      end
   end

   // Next-state logic for queue pointers, redirect, epoch and control state.
   always_comb begin
      state_d       = state_q;
      epoch_d       = epoch_q;
      redir_valid_d = 1'b0;
      redir_pc_d    = redir_pc_q;
      wptr_d        = wptr_q;
      rptr_d        = rptr_q;
      count_d       = count_q;
      if (be_flush) begin
         // Flush wins over everything, including a same-cycle predicted redirect.
         state_d       = ST_RUN;
         epoch_d       = epoch_q + EPOCH_W'(1);
         redir_valid_d = 1'b1;
         redir_pc_d    = be_flush_pc;
         wptr_d        = '0;
         rptr_d        = '0;
         count_d       = '0;
      end else begin
         if (accept) begin
            wptr_d = wptr_q + PTR_W'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
         end
         if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
         end
         if (accept && wr_taken) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = wr_target;
            epoch_d       = epoch_q + EPOCH_W'(1);
         end
         if (accept && (dec_cat == CAT_JIRL)) begin
            state_d = ST_BLOCK;
         end
      end
   end

   // Control state register bank with asynchronous clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_RUN;
         epoch_q       <= '0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         epoch_q       <= epoch_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         count_q       <= count_d;
      end
   end

   // Head entry presentation; data reads as zero while the queue is empty.
   always_comb begin
      head_entry = mem_q[rptr_q];
      if (empty) begin
         head_entry = '0;
      end
   end

   assign if_ready      = !full;
   assign id_valid      = !empty;
   assign id_pc         = head_entry.pc;
   assign id_inst       = head_entry.inst;
   assign id_pred_taken = head_entry.pred_taken;
   assign id_pred_pc    = head_entry.pred_pc;
   assign occupancy     = count_q;
   assign cur_epoch     = epoch_q;
   assign redir_valid   = redir_valid_q;
   assign redir_pc      = redir_pc_q;

endmodule

// File: tb/tb_fetch_steer_queue.sv
// Directed plus randomized bench for fetch_steer_queue. A queue-based
// reference model derives expectations from the instruction encoding.
module tb_fetch_steer_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rstn;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [1:0]  if_epoch;
   logic [1:0]  cur_epoch;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_pred_taken;
   logic [31:0] id_pred_pc;
   logic        be_flush;
   logic [31:0] be_flush_pc;
   logic [3:0]  occupancy;

   fetch_steer_queue #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_pc         (if_pc),
      .if_inst       (if_inst),
      .if_epoch      (if_epoch),
      .cur_epoch     (cur_epoch),
      .redir_valid   (redir_valid),
      .redir_pc      (redir_pc),
      .id_valid      (id_valid),
      .id_ready      (id_ready),
      .id_pc         (id_pc),
      .id_inst       (id_inst),
      .id_pred_taken (id_pred_taken),
      .id_pred_pc    (id_pred_pc),
      .be_flush      (be_flush),
      .be_flush_pc   (be_flush_pc),
      .occupancy     (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        taken;
      logic [31:0] ppc;
   } ent_t;

   ent_t        mq[$];
   int          m_epoch;
   bit          m_block;
   logic        m_rv;
   logic [31:0] m_rpc;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [31:0] PLAIN = 32'h0280_0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Prediction from the instruction-set rules using integer offsets.
   function automatic void predict(input logic [31:0] pc, input logic [31:0] inst,
                                   output logic taken, output logic [31:0] ppc, output bit jirl);
      int op, o16, o26;
      op  = int'(inst[31:26]);
      o16 = int'(inst[25:10]);
      if (o16 >= 32768) o16 -= 65536;
      o26 = int'({inst[9:0], inst[25:10]});
      if (o26 >= 33554432) o26 -= 67108864;
      jirl  = (op == 19);
      taken = 1'b0;
      ppc   = pc + 32'd4;
      if (op == 20 || op == 21) begin
         taken = 1'b1;
         ppc   = pc + 32'(o26 * 4);
      end else if (op >= 22 && op <= 27 && o16 < 0) begin
         taken = 1'b1;
         ppc   = pc + 32'(o16 * 4);
      end
   endfunction

   function automatic logic [31:0] mk_b(input int off);
      logic [25:0] o;
      o = 26'(off >>> 2);
      return {6'h14, o[15:0], o[25:16]};
   endfunction

   function automatic logic [31:0] mk_bcond(input logic [5:0] op, input int off);
      logic [15:0] o;
      o = 16'(off >>> 2);
      return {op, o, 5'd4, 5'd5};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_epoch = 0;
      m_block = 0;
      m_rv    = 1'b0;
      m_rpc   = 32'h0;
   endtask

   task automatic model_step();
      ent_t e;
      bit   acc, pop, jirl;
      acc = if_valid && (mq.size() != DEPTH) && (if_epoch == 2'(m_epoch)) && !m_block && !be_flush;
      pop = id_ready && (mq.size() != 0) && !be_flush;
      if (be_flush) begin
         mq.delete();
         m_rv    = 1'b1;
         m_rpc   = be_flush_pc;
         m_epoch = (m_epoch + 1) % 4;
         m_block = 0;
      end else begin
         m_rv = 1'b0;
         if (pop) void'(mq.pop_front());
         if (acc) begin
            predict(if_pc, if_inst, e.taken, e.ppc, jirl);
            e.pc   = if_pc;
            e.inst = if_inst;
            mq.push_back(e);
            if (e.taken) begin
               m_rv    = 1'b1;
               m_rpc   = e.ppc;
               m_epoch = (m_epoch + 1) % 4;
            end
            if (jirl) m_block = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("occupancy", 32'(occupancy), mq.size());
      chk("if_ready", 32'(if_ready), 32'(mq.size() != DEPTH));
      chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
      chk("cur_epoch", 32'(cur_epoch), m_epoch);
      chk("redir_valid", 32'(redir_valid), 32'(m_rv));
      chk("redir_pc", redir_pc, m_rpc);
      if (mq.size() != 0) begin
         chk("id_pc", id_pc, mq[0].pc);
         chk("id_inst", id_inst, mq[0].inst);
         chk("id_pred_taken", 32'(id_pred_taken), 32'(mq[0].taken));
         chk("id_pred_pc", id_pred_pc, mq[0].ppc);
      end else begin
         chk("id_pc_empty", id_pc, 32'h0);
         chk("id_pred_pc_empty", id_pred_pc, 32'h0);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [1:0] ep, input logic rdy, input logic fl, input logic [31:0] fpc);
      if_valid    = v;
      if_pc       = pc;
      if_inst     = inst;
      if_epoch    = ep;
      id_ready    = rdy;
      be_flush    = fl;
      be_flush_pc = fpc;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive(1'b0, 32'h0, 32'h0, 2'(m_epoch), 1'b1, 1'b0, 32'h0);
         cycle();
      end
   endtask

   initial begin
      logic [31:0] r32, rpc;
      int          sel;

      // Reset state
      rstn = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
      model_reset();
      #2;
      check_all();
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Fill with plain beats, then one pop from full
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1c00_0000 + 32'(4 * i), PLAIN, 2'd0, 1'b0, 1'b0, 32'h0);
         cycle();
      end
      chk("occ_after_4", 32'(occupancy), 32'd4);
      chk("ready_after_4", 32'(if_ready), 32'd1);
      for (int i = 4; i < 8; i++) begin
         drive(1'b1, 32'h1c00_0000 + 32'(4 * i), PLAIN, 2'd0, 1'b0, 1'b0, 32'h0);
         cycle();
      end
      chk("occ_full", 32'(occupancy), 32'd8);
      chk("ready_full", 32'(if_ready), 32'd0);
      drive(1'b1, 32'h1c00_0020, PLAIN, 2'd0, 1'b1, 1'b0, 32'h0);
      cycle();
      chk("ready_after_pop", 32'(if_ready), 32'd1);
      chk("occ_after_pop", 32'(occupancy), 32'd7);
      chk("head_after_pop", id_pc, 32'h1c00_0004);
      drain();

      // Taken b, then stale-epoch beat dropped
      drive(1'b1, 32'h1c00_0100, mk_b(32'h40), 2'd0, 1'b0, 1'b0, 32'h0);
      cycle();
      chk("b_redir_valid", 32'(redir_valid), 32'd1);
      chk("b_redir_pc", redir_pc, 32'h1c00_0140);
      chk("b_epoch", 32'(cur_epoch), 32'd1);
      drive(1'b1, 32'h1c00_0104, PLAIN, 2'd0, 1'b0, 1'b0, 32'h0);
      cycle();
      chk("stale_dropped_occ", 32'(occupancy), 32'd1);
      chk("redir_pulse_end", 32'(redir_valid), 32'd0);
      drain();

      // Backward bne taken, forward beq not taken
      drive(1'b1, 32'h1c00_0200, mk_bcond(6'h17, -8), 2'd1, 1'b0, 1'b0, 32'h0);
      cycle();
      chk("bne_redir_pc", redir_pc, 32'h1c00_01f8);
      chk("bne_pred_taken", 32'(id_pred_taken), 32'd1);
      drain();
      drive(1'b1, 32'h1c00_0300, mk_bcond(6'h16, 32), 2'd2, 1'b0, 1'b0, 32'h0);
      cycle();
      chk("beq_no_redir", 32'(redir_valid), 32'd0);
      chk("beq_pred_pc", id_pred_pc, 32'h1c00_0304);
      drain();

      // jirl blocks, three beats dropped, flush releases
      drive(1'b1, 32'h1c00_0400, {6'h13, 16'h0, 5'd1, 5'd0}, 2'd2, 1'b0, 1'b0, 32'h0);
      cycle();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 32'h1c00_0400 + 32'(4 * i), PLAIN, 2'd2, 1'b0, 1'b0, 32'h0);
         cycle();
         chk("block_occ", 32'(occupancy), 32'd1);
      end
      drive(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 32'h1c00_8000);
      cycle();
      chk("flush_occ", 32'(occupancy), 32'd0);
      chk("flush_redir_pc", redir_pc, 32'h1c00_8000);
      chk("flush_epoch", 32'(cur_epoch), 32'd3);
      drive(1'b1, 32'h1c00_8000, PLAIN, 2'd3, 1'b0, 1'b0, 32'h0);
      cycle();
      chk("run_after_flush", 32'(occupancy), 32'd1);
      drain();

      // Taken b and flush in the same cycle
      drive(1'b1, 32'h1c00_0700, mk_b(32'h40), 2'd3, 1'b0, 1'b1, 32'h1c00_0800);
      cycle();
      chk("coll_redir_pc", redir_pc, 32'h1c00_0800);
      chk("coll_occ", 32'(occupancy), 32'd0);
      chk("coll_epoch_wrap", 32'(cur_epoch), 32'd0);
      drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
      cycle();
      chk("coll_single_pulse", 32'(redir_valid), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         r32 = $urandom();
         rpc = $urandom() & 32'hffff_fffc;
         sel = $urandom_range(0, 19);
         if (sel < 5)       r32 = {6'h14 + 6'($urandom_range(0, 1)), r32[25:0]};
         else if (sel < 10) r32 = {6'(22 + $urandom_range(0, 5)), r32[25:0]};
         else if (sel == 10) r32 = {6'h13, r32[25:0]};
         drive($urandom_range(0, 3) != 0, rpc, r32,
               ($urandom_range(0, 4) != 0) ? 2'(m_epoch) : 2'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1,
               m_block ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0),
               $urandom() & 32'hffff_fffc);
         cycle();
      end

      // Fill to full, pop under full, then asynchronous reset mid-stream
      drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h1c00_9000);
      cycle();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h1c00_a000 + 32'(4 * i), PLAIN, 2'(m_epoch), 1'b0, 1'b0, 32'h0);
         cycle();
      end
      chk("refill_full", 32'(occupancy), 32'd8);
      drive(1'b1, 32'h1c00_a020, PLAIN, 2'(m_epoch), 1'b1, 1'b0, 32'h0);
      cycle();
      drive(1'b1, 32'h1c00_a020, PLAIN, 2'(m_epoch), 1'b1, 1'b0, 32'h0);
      cycle();
      chk("push_pop_occ", 32'(occupancy), 32'd7);
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_rst_occ", 32'(occupancy), 32'd0);
      chk("async_rst_redir_pc", redir_pc, 32'h0);
      chk("async_rst_epoch", 32'(cur_epoch), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      drive(1'b1, 32'h1c00_b000, PLAIN, 2'd0, 1'b0, 1'b0, 32'h0);
      cycle();
      chk("post_rst_no_redir", 32'(redir_valid), 32'd0);
      chk("post_rst_occ", 32'(occupancy), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
